// File: rtl/program_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : program_pkg
//  Purpose  : Shared definitions for the program loader and the program
//             ROM/memory side: loader state encoding, ROM word width and the
//             opcode/operand field positions inside a ROM word.
//  Revision : 1.0 - initial release
// ============================================================================
package program_pkg;

    // Loader state encoding; ST_CHK is only reachable in checksum builds
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_e;

    // ROM word layout: opcode in the upper half, operand in the lower half
    localparam int c_ROM_WORD_W   = 32;
    localparam int c_FIELD_W      = 16;
    localparam int c_OPCODE_MSB   = 31;
    localparam int c_OPCODE_LSB   = 16;
    localparam int c_OPERAND_MSB  = 15;
    localparam int c_OPERAND_LSB  = 0;

    // Build a ROM word from its opcode and operand fields
    function automatic logic [c_ROM_WORD_W-1:0] pack_word(
        input logic [c_FIELD_W-1:0] opcode,
        input logic [c_FIELD_W-1:0] operand
    );
        logic [c_ROM_WORD_W-1:0] w;
        w = '0;
        w[c_OPCODE_MSB:c_OPCODE_LSB]   = opcode;
        w[c_OPERAND_MSB:c_OPERAND_LSB] = operand;
        return w;
    endfunction

endpackage : program_pkg
`default_nettype wire

// File: rtl/program_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : byte_assembler
//  Purpose  : Collects accepted stream bytes into big-endian 32-bit words.
//             The first three bytes of a word are held in a shift register;
//             the fourth is taken straight from the input so the full word
//             is available in the same cycle the last byte is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_assembler
    import program_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_accept,
    input  logic [7:0]              i_byte,
    output logic                    o_word_done,
    output logic [c_ROM_WORD_W-1:0] o_word
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q,   cnt_d;

    // Shift in accepted bytes; the counter wraps to 0 after the 4th byte
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (i_accept) begin
            shift_d = {shift_q[15:0], i_byte};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // Byte position and partial-word registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_word_done = i_accept && !i_clr && (cnt_q == 2'd3);
    assign o_word      = pack_word(shift_q[23:8], {shift_q[7:0], i_byte});

endmodule : byte_assembler
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Loads a byte stream (header word count N, then N big-endian
//             32-bit words) into program memory, one write pulse per word.
//  Options  : LOADER_CHECKSUM_EN - adds an 8-bit XOR checksum byte after the
//             data; mismatch ends the load in error (written words remain).
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader
    import program_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [2*DATA_WIDTH-1:0] mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    loader_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]     addr_q,  addr_d;
    logic [2*DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                      we_q,    we_d;
    logic [DATA_WIDTH-1:0]     idx_q,   idx_d;
    logic [7:0]                n_q,     n_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                csum_q,  csum_d;
`endif

    logic                      w_accept;
    logic                      w_start_load;
    logic                      w_word_done;
    logic [c_ROM_WORD_W-1:0]   w_word;
    logic                      w_last_word;

    assign w_accept    = in_valid && in_ready;
    assign w_last_word = (idx_q == DATA_WIDTH'(n_q - 8'd1));

    byte_assembler u_byte_assembler (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start_load),
        .i_accept    (w_accept && (state_q == ST_DATA)),
        .i_byte      (in_byte),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    // Next-state logic: header check, per-word write pulse, optional checksum
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        idx_d        = idx_q;
        n_d          = n_q;
        w_start_load = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d      = ST_HDR;
                    idx_d        = '0;
                    n_d          = '0;
                    w_start_load = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d       = '0;
`endif
                end
            end
            ST_HDR: begin
                if (w_accept) begin
                    n_d = in_byte;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = in_byte;
`endif
                    if ((in_byte == 8'd0) || (int'(in_byte) > DEPTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_byte;
`endif
                    if (w_word_done) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q;
                        wdata_d = (2*DATA_WIDTH)'(w_word);
                        idx_d   = idx_q + DATA_WIDTH'(1);
                        if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_accept) begin
                    state_d = (in_byte == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset also drops a pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            n_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Reset masks the write strobe at once so a pulse already registered
    // for the current cycle never reaches memory.
    assign mem_we    = we_q && !rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign in_ready  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign busy      = in_ready;
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Directed self-checking bench for program_loader.
//  Options  : LOADER_CHECKSUM_EN - must match the RTL build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [7:0]              in_byte;
    logic                    in_valid;
    logic                    in_ready;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_addr;
    logic [2*DATA_WIDTH-1:0] mem_wdata;
    logic                    busy;
    logic                    done;
    logic                    error;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cnt = 0;

    program_loader #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Record every memory write, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks begin and end 1 time unit after a rising edge
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            in_valid = 1'b0;
            in_byte  = 8'h5A;
            @(posedge clk); #1;
        end
        in_byte  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000", {in_ready, mem_we, busy, done, error});
        end
        checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got addr %h data %h required 0 0", mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int base = wr_cnt;
        do_start();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_hdr_busy: got busy %b ready %b required 1 1", busy, in_ready);
        end
        send_byte(8'h02, 0);
        send_byte(8'h30, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h31, 0);
`endif
        @(negedge clk); #1;
        checks++;
        if (wr_cnt - base !== 2) begin
            errors++;
            $display("FAIL basic_write_count: got %0d required 2", wr_cnt - base);
        end
        checks++;
        if (wr_addr[base] !== 16'd0 || wr_data[base] !== 32'h3001_0005) begin
            errors++;
            $display("FAIL basic_word0: got addr %h data %h required 0000 30010005", wr_addr[base], wr_data[base]);
        end
        checks++;
        if (wr_addr[base+1] !== 16'd1 || wr_data[base+1] !== 32'h0000_0007) begin
            errors++;
            $display("FAIL basic_word1: got addr %h data %h required 0001 00000007", wr_addr[base+1], wr_data[base+1]);
        end
        checks++;
        if ({done, busy, error, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_status: got done/busy/err/rdy %b required 1000", {done, busy, error, in_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 16'd1 || mem_wdata !== 32'h0000_0007) begin
            errors++;
            $display("FAIL basic_hold: got we %b addr %h data %h required 0 0001 00000007", mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_bad_header();
        int base = wr_cnt;
        do_start();
        send_byte(8'h00, 0);
        checks++;
        if ({error, busy, done, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL hdr_zero: got err/busy/done/rdy %b required 1000", {error, busy, done, in_ready});
        end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (wr_cnt - base !== 0 || error !== 1'b1) begin
            errors++;
            $display("FAIL hdr_zero_hold: got writes %0d err %b required 0 1", wr_cnt - base, error);
        end
        do_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_err: got err %b busy %b required 0 1", error, busy);
        end
        send_byte(8'h11, 0);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hdr_too_big: got err %b busy %b required 1 0", error, busy);
        end
        do_start();
        send_byte(8'h10, 0);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hdr_depth_ok: got err %b busy %b required 0 1", error, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (wr_cnt - base !== 0) begin
            errors++;
            $display("FAIL hdr_no_writes: got %0d required 0", wr_cnt - base);
        end
    endtask

    task automatic test_gaps();
        logic [7:0]  stream [13];
        logic [31:0] exp_w  [3];
        stream = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h01,
                   8'hFF, 8'hEE, 8'hDD, 8'hCC};
        exp_w  = '{32'hA1B2_C3D4, 32'h0000_0001, 32'hFFEE_DDCC};
        for (int mode = 0; mode < 2; mode++) begin
            int base = wr_cnt;
            do_start();
            for (int i = 0; i < 13; i++) begin
                send_byte(stream[i], (mode == 1) ? int'($urandom_range(0, 3)) : 0);
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(8'h06, (mode == 1) ? 2 : 0);
`endif
            @(negedge clk); #1;
            checks++;
            if (wr_cnt - base !== 3 || done !== 1'b1) begin
                errors++;
                $display("FAIL gaps_mode%0d_count: got writes %0d done %b required 3 1", mode, wr_cnt - base, done);
            end
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (wr_addr[base+w] !== 16'(w) || wr_data[base+w] !== exp_w[w]) begin
                    errors++;
                    $display("FAIL gaps_mode%0d_word%0d: got addr %h data %h required %h %h",
                             mode, w, wr_addr[base+w], wr_data[base+w], 16'(w), exp_w[w]);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        int base = wr_cnt;
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pulse: got mem_we %b required 0", mem_we);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, mem_we, busy, done, error} !== 5'b0 || mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got flags %b addr %h data %h required 00000 0 0",
                     {in_ready, mem_we, busy, done, error}, mem_addr, mem_wdata);
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (wr_cnt - base !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: got writes %0d busy %b required 0 0", wr_cnt - base, busy);
        end
    endtask

    task automatic test_start_ignored();
        int base = wr_cnt;
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        do_start();
        checks++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_busy: got busy %b err %b required 1 0", busy, error);
        end
        send_byte(8'hCC, 0); send_byte(8'hDD, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h06, 0);
`endif
        @(negedge clk); #1;
        checks++;
        if (wr_cnt - base !== 2 || wr_data[base] !== 32'hAABB_CCDD || wr_addr[base] !== 16'd0
            || wr_data[base+1] !== 32'h0102_0304 || wr_addr[base+1] !== 16'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_load: got writes %0d w0 %h@%h w1 %h@%h done %b required 2 aabbccdd@0 01020304@1 1",
                     wr_cnt - base, wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1], done);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            int base = wr_cnt;
            do_start();
            send_byte(8'h01, 0);
            send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL csum%0d_chk_state: got busy %b rdy %b done %b required 1 1 0", k, busy, in_ready, done);
            end
            send_byte((k == 0) ? 8'h45 : 8'h00, 0);
            checks++;
            if (done !== (k == 0) || error !== (k == 1)) begin
                errors++;
                $display("FAIL csum%0d_result: got done %b err %b required %b %b", k, done, error, k == 0, k == 1);
            end
            checks++;
            if (wr_cnt - base !== 1 || wr_data[base] !== 32'h1122_3344 || wr_addr[base] !== 16'd0) begin
                errors++;
                $display("FAIL csum%0d_word: got writes %0d data %h addr %h required 1 11223344 0000",
                         k, wr_cnt - base, wr_data[base], wr_addr[base]);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        test_reset();
        test_basic();
        test_bad_header();
        test_gaps();
        test_rst_mid();
        test_start_ignored();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_program_loader
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning operand/opcode half-word width (memory word = 2*DATA_WIDTH).
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of program-memory words.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port in_byte  input  8  incoming stream byte.
REQ-007 SHALL have port in_valid  input  1  in_byte valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_byte this cycle.
REQ-009 SHALL have port mem_we  output  1  program-memory write strobe.
REQ-010 SHALL have port mem_addr  output  DATA_WIDTH  write address.
REQ-011 SHALL have port mem_wdata  output  2*DATA_WIDTH  write word, [31:16] opcode, [15:0] operand.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  load completed successfully.
REQ-014 SHALL have port error  output  1  load aborted.

Function
REQ-015 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1.
REQ-016 SHALL implement states IDLE, HDR, DATA, CHK (only with checksum enabled), DONE, ERR.
REQ-017 SHALL move IDLE/DONE/ERR -> HDR on start, clearing done, error, address counter and byte counter.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL take the first accepted byte in HDR as word count N; N in 1..DEPTH -> DATA; N=0 or N>DEPTH -> ERR.
REQ-020 SHALL assemble each word from 4 accepted bytes, big-endian (first byte -> [31:24]).
REQ-021 SHALL assert mem_we for exactly one cycle, the cycle after the 4th byte of a word is accepted, with mem_addr = word index (0..N-1) and mem_wdata = assembled word.
REQ-022 SHALL drive in_ready = 1 in HDR, DATA, CHK and 0 in IDLE, DONE, ERR; no stall is required for the write cycle.
REQ-023 SHALL after the write of word N-1 go to DONE (checksum disabled) or CHK (enabled).
REQ-024 SHALL hold busy = 1 in HDR, DATA, CHK; done = 1 only in DONE; error = 1 only in ERR; both held until next start or rst.
REQ-025 SHALL tolerate in_valid gaps of any length without losing partial word state.
REQ-026 SHALL keep mem_addr/mem_wdata stable when mem_we = 0 (last written values).

Reset
REQ-027 SHALL on rst enter IDLE with in_ready, mem_we, busy, done, error = 0 and mem_addr, mem_wdata, counters, checksum = 0.
REQ-028 SHALL on rst mid-load abandon the load immediately with no further mem_we, including a pending write pulse.

Configuration
REQ-029 SHALL, with LOADER_CHECKSUM_EN defined, maintain an 8-bit XOR of the header and all data bytes and in CHK accept one byte: equal -> DONE, unequal -> ERR (already-written words remain).
REQ-030 SHALL, without LOADER_CHECKSUM_EN, omit CHK state and checksum register; the stream ends after the last data byte.

Structure
REQ-031 SHALL place state encoding typedef, ROM word width constant (32) and opcode/operand field positions in shared package program_pkg, shared with the ROM/memory side.
REQ-032 SHALL be a single module; a sub-module byte_assembler (4-byte shift register plus 2-bit counter) is permitted.

Verification
REQ-033 SHALL cover: start; bytes 02,30,01,00,05,00,00,00,07 -> mem_we at addr 0 data 0x30010005, addr 1 data 0x00000007, then done=1, busy=0.
REQ-034 SHALL cover: header 00 -> error=1 next cycle, no mem_we; header 11 (17>DEPTH) -> error=1.
REQ-035 SHALL cover: in_valid toggled 1-0-0-1 randomly across load of N=3 -> identical writes to back-to-back case.
REQ-036 SHALL cover: rst asserted the cycle after 4th byte of word 0 -> no mem_we, all outputs 0, state IDLE.
REQ-037 SHALL cover (LOADER_CHECKSUM_EN): N=1, data 11,22,33,44, checksum 01^11^22^33^44=0x45 -> done; checksum 0x00 -> error, word 0x11223344 still written.
REQ-038 SHALL cover: start pulsed during DATA -> ignored, load completes normally.
